ddr_mem_arbiter: RTL and testbench
==================================

DDR_MEM_ARBITER -- requirements
Module: ddr_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 31, DDR2 controller word address width.
REQ-002 SHALL have parameter DATA_W, default 128, controller user-data width.
REQ-003 SHALL have parameter VID_MAX, default 4, maximum consecutive video grants while another requester waits.
REQ-004 SHALL have parameter RD_TMO, default 255, read-return timeout in cycles.
REQ-005 SHALL have port clk, input, 1, single clock; the block has one clock, and reset is synchronous and active-high.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port phy_init_done, input, 1; no arbitration while low.
REQ-008 SHALL have port req, input, 3, request per requester: bit0 cache, bit1 NPU, bit2 video.
REQ-009 SHALL have port we, input, 3, per-requester write flag.
REQ-010 SHALL have port addr, input, 3*ADDR_W, flattened per-requester address, slot i at [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port wdata, input, 3*DATA_W, flattened per-requester write data.
REQ-012 SHALL have port gnt, output, 3, one-hot pulse: command accepted by controller.
REQ-013 SHALL have port rvalid, output, 3, one-hot pulse: read data returned.
REQ-014 SHALL have port rdata, output, DATA_W, shared read data, valid with rvalid.
REQ-015 SHALL have port rd_err, output, 1, one-cycle pulse on read timeout.
REQ-016 SHALL have ports mc_req/mc_we (output, 1), mc_addr (output, ADDR_W), mc_wdata (output, DATA_W), mc_rdy (input, 1), mc_rvalid (input, 1), mc_rdata (input, DATA_W) to the DDR2 controller.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT_RD.
REQ-018 IDLE: if phy_init_done and any req, pick winner, latch its we/addr/wdata, go ISSUE next cycle; else stay.
REQ-019 Pick: video wins if requesting, unless vid_cnt==VID_MAX and bit0 or bit1 requests; otherwise round-robin between cache/NPU starting from rr_ptr.
REQ-020 ISSUE: mc_req=1 with latched command; gnt[winner]=mc_req&&mc_rdy (combinational on mc_rdy); mc_req stays high until mc_rdy.
REQ-021 On accept: write -> IDLE; read -> WAIT_RD with timeout counter cleared.
REQ-022 WAIT_RD: on mc_rvalid, rdata=mc_rdata and rvalid[winner]=1 for one cycle, -> IDLE.
REQ-023 WAIT_RD: if timeout counter reaches RD_TMO without mc_rvalid, pulse rd_err, -> IDLE; a later stray mc_rvalid is ignored.
REQ-024 mc_rvalid in IDLE or ISSUE SHALL be ignored (no rvalid).
REQ-025 Latency: req seen in IDLE at cycle N -> mc_req at N+1; one IDLE bubble between transactions.
REQ-026 rr_ptr SHALL advance past a cache/NPU winner at its gnt; unchanged on video grants.
REQ-027 vid_cnt SHALL increment (saturating at VID_MAX) on video gnt while bit0/bit1 requests, and clear on any non-video gnt or when no other requester waits.
REQ-028 Requesters SHALL hold req/we/addr/wdata until gnt; the arbiter uses only latched values after IDLE.
REQ-029 phy_init_done falling mid-transaction SHALL NOT abort it; it only blocks new picks.

Reset
REQ-030 On rst: state IDLE, rr_ptr=cache, vid_cnt=0, timeout=0, mc_req=0, gnt=0, rvalid=0, rd_err=0, rdata=0, latched command=0.
REQ-031 rst mid-transaction SHALL abandon it; returned read data SHALL be discarded.

Structure
REQ-032 Package mem_arb_pkg SHALL hold FSM state encoding, requester index constants (REQ_CACHE=0, REQ_NPU=1, REQ_VID=2), and default parameter values.
REQ-033 Winner selection SHALL be a combinational sub-module mem_arb_picker (inputs req, rr_ptr, vid_block; output one-hot winner).

Verification
REQ-034 phy_init_done=0, req=3'b111 for 20 cycles -> no mc_req and no gnt; raise phy_init_done -> gnt=3'b100 first.
REQ-035 Cache write, addr=0x100, mc_rdy=1 -> mc_req one cycle after req, gnt=3'b001 same cycle, mc_addr=0x100, mc_we=1.
REQ-036 Cache and NPU both reading continuously -> gnts alternate 001,010,001,...; each rvalid follows mc_rvalid by 0 cycles with correct rdata.
REQ-037 Video and cache reqs held, VID_MAX=4 -> four video gnts, then one cache gnt, then video again.
REQ-038 NPU read, mc_rvalid withheld -> rd_err pulses at RD_TMO cycles after accept, FSM IDLE, late mc_rvalid produces no rvalid.
REQ-039 rst asserted in WAIT_RD -> next cycle all outputs zero, state IDLE; subsequent mc_rvalid ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the DDR2 memory arbiter: FSM encoding, requester
// indices and default parameter values.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_state_t;

  localparam int REQ_CACHE = 0;
  localparam int REQ_NPU   = 1;
  localparam int REQ_VID   = 2;
  localparam int N_REQ     = 3;

  localparam int DEF_ADDR_W  = 31;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_VID_MAX = 4;
  localparam int DEF_RD_TMO  = 255;

  // Encode a one-hot requester vector to its slot index
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    case (oh)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection: video first unless its streak is exhausted
// while others wait, otherwise round-robin between cache and NPU.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       rr_ptr,
  input  logic       vid_block,
  output logic [2:0] winner
);

  logic others_s;

  assign others_s = req[REQ_CACHE] | req[REQ_NPU];

  // Priority/round-robin pick; rr_ptr=0 favours cache, 1 favours NPU
  always_comb begin
    winner = 3'b000;
    if (req[REQ_VID] && !(vid_block && others_s)) begin
      winner = 3'b100;
    end else if (rr_ptr == 1'b0) begin
      if (req[REQ_CACHE]) begin
        winner = 3'b001;
      end else if (req[REQ_NPU]) begin
        winner = 3'b010;
      end else begin
        winner = 3'b000;
      end
    end else begin
      if (req[REQ_NPU]) begin
        winner = 3'b010;
      end else if (req[REQ_CACHE]) begin
        winner = 3'b001;
      end else begin
        winner = 3'b000;
      end
    end
  end

endmodule

// File: rtl/ddr_mem_arbiter.sv
// Three-requester arbiter in front of a DDR2 controller user port: one
// command in flight at a time, with a read-return timeout.
module ddr_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int VID_MAX = DEF_VID_MAX,
  parameter int RD_TMO  = DEF_RD_TMO
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                phy_init_done,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                rd_err,
  output logic                mc_req,
  output logic                mc_we,
  output logic [ADDR_W-1:0]   mc_addr,
  output logic [DATA_W-1:0]   mc_wdata,
  input  logic                mc_rdy,
  input  logic                mc_rvalid,
  input  logic [DATA_W-1:0]   mc_rdata
);

  localparam int TMO_W = $clog2(RD_TMO + 1);
  localparam int VC_W  = $clog2(VID_MAX + 1);

  arb_state_t        state_r, state_s;
  logic [2:0]        win_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rr_ptr_r;
  logic [VC_W-1:0]   vid_cnt_r;
  logic [TMO_W-1:0]  tmo_r;

  logic [2:0]        pick_s;
  logic [1:0]        pick_idx_s;
  logic              vid_block_s;
  logic              start_s;
  logic [2:0]        gnt_s;
  logic [2:0]        rvalid_s;
  logic [DATA_W-1:0] rdata_s;
  logic              rd_err_s;
  logic              others_s;

  assign vid_block_s = (vid_cnt_r == VC_W'(VID_MAX));
  assign pick_idx_s  = onehot_to_idx(pick_s);
  assign start_s     = (state_r == ST_IDLE) && phy_init_done && (req != 3'b000);
  assign others_s    = req[REQ_CACHE] | req[REQ_NPU];

  mem_arb_picker u_picker (
    .req       (req),
    .rr_ptr    (rr_ptr_r),
    .vid_block (vid_block_s),
    .winner    (pick_s)
  );

  // Next-state and per-cycle response pulses
  always_comb begin
    state_s  = state_r;
    gnt_s    = 3'b000;
    rvalid_s = 3'b000;
    rdata_s  = '0;
    rd_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mc_rdy) begin
          gnt_s   = win_r;
          state_s = we_r ? ST_IDLE : ST_WAIT_RD;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT_RD: begin
        if (mc_rvalid) begin
          rvalid_s = win_r;
          rdata_s  = mc_rdata;
          state_s  = ST_IDLE;
        end else if (tmo_r == TMO_W'(RD_TMO - 1)) begin
          rd_err_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          state_s  = ST_WAIT_RD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted so an abandoned read
  // cannot leak a pulse in the reset cycle itself.
  assign gnt      = rst ? 3'b000 : gnt_s;
  assign rvalid   = rst ? 3'b000 : rvalid_s;
  assign rdata    = rst ? '0 : rdata_s;
  assign rd_err   = rst ? 1'b0 : rd_err_s;
  assign mc_req   = (state_r == ST_ISSUE) && !rst;
  assign mc_we    = we_r;
  assign mc_addr  = addr_r;
  assign mc_wdata = wdata_r;

  // State, latched command, fairness and timeout bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      win_r     <= 3'b000;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rr_ptr_r  <= 1'b0;
      vid_cnt_r <= '0;
      tmo_r     <= '0;
    end else begin
      state_r <= state_s;

      if (start_s) begin
        win_r   <= pick_s;
        we_r    <= we[pick_idx_s];
        addr_r  <= addr[int'(pick_idx_s)*ADDR_W +: ADDR_W];
        wdata_r <= wdata[int'(pick_idx_s)*DATA_W +: DATA_W];
      end else begin
        win_r   <= win_r;
        we_r    <= we_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end

      if (state_r == ST_ISSUE) begin
        tmo_r <= '0;
      end else if (state_r == ST_WAIT_RD) begin
        tmo_r <= tmo_r + TMO_W'(1);
      end else begin
        tmo_r <= tmo_r;
      end

      if (gnt_s[REQ_CACHE]) begin
        rr_ptr_r <= 1'b1;
      end else if (gnt_s[REQ_NPU]) begin
        rr_ptr_r <= 1'b0;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end

      // Video streak only grows while someone else is being held off
      if (gnt_s[REQ_VID] && others_s) begin
        vid_cnt_r <= vid_block_s ? vid_cnt_r : vid_cnt_r + VC_W'(1);
      end else if ((gnt_s != 3'b000) || !others_s) begin
        vid_cnt_r <= '0;
      end else begin
        vid_cnt_r <= vid_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_ddr_mem_arbiter.sv
// Randomized scoreboard bench for ddr_mem_arbiter: a transaction-level model
// predicts each cycle's controller-side and requester-side behaviour.
module tb_ddr_mem_arbiter;

  localparam int ADDR_W  = 31;
  localparam int DATA_W  = 128;
  localparam int VID_MAX = 4;
  localparam int RD_TMO  = 20;
  localparam int N_CYC   = 4000;
  localparam int P_FREE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_WAIT  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                phy_init_done;
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                rd_err;
  logic                mc_req;
  logic                mc_we;
  logic [ADDR_W-1:0]   mc_addr;
  logic [DATA_W-1:0]   mc_wdata;
  logic                mc_rdy;
  logic                mc_rvalid;
  logic [DATA_W-1:0]   mc_rdata;

  always #5 clk = ~clk;

  ddr_mem_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .VID_MAX (VID_MAX), .RD_TMO (RD_TMO)
  ) dut (
    .clk (clk), .rst (rst), .phy_init_done (phy_init_done),
    .req (req), .we (we), .addr (addr), .wdata (wdata),
    .gnt (gnt), .rvalid (rvalid), .rdata (rdata), .rd_err (rd_err),
    .mc_req (mc_req), .mc_we (mc_we), .mc_addr (mc_addr), .mc_wdata (mc_wdata),
    .mc_rdy (mc_rdy), .mc_rvalid (mc_rvalid), .mc_rdata (mc_rdata)
  );

  typedef struct {
    int                cyc;
    logic              mc_req;
    logic              chk_zero;
    logic              has_cmd;
    int                cmd_idx;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              has_rsp;
    logic              rsp_err;
    int                rsp_idx;
    logic [DATA_W-1:0] rsp_data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic mon_en      = 1'b0;

  // Requester state: each holds at most one transaction until granted
  logic [2:0]        pend;
  logic [2:0]        pop_pend;
  logic              cur_we[3];
  logic [ADDR_W-1:0] cur_addr[3];
  logic [DATA_W-1:0] cur_wdata[3];

  // Reference model state
  int                phase;
  int                act_idx;
  logic              act_we;
  logic [ADDR_W-1:0] act_addr;
  logic [DATA_W-1:0] act_wdata;
  int                wait_k;
  logic              withhold;
  int                streak;
  logic              rr_npu;

  task automatic chk(input string nm, input int cy,
                     input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cy, act, want);
    end
  endtask

  function automatic int model_pick(input logic [2:0] p, input int stk, input logic rrn);
    if (p[2] && !(stk == VID_MAX && (p[0] || p[1]))) return 2;
    if (p[0] && p[1]) return rrn ? 1 : 0;
    return p[0] ? 0 : 1;
  endfunction

  task automatic new_txn(input int i);
    pend[i]      = 1'b1;
    cur_we[i]    = ($urandom_range(0, 99) < 40);
    cur_addr[i]  = ADDR_W'($urandom);
    cur_wdata[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Monitor: pops one expectation per cycle and compares at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", -1, DATA_W'(1), DATA_W'(0));
        end else begin
          e = exp_q.pop_front();
          chk("mc_req", e.cyc, DATA_W'(mc_req), DATA_W'(e.mc_req));
          if (e.chk_zero) begin
            chk("rst_mc_addr", e.cyc, DATA_W'(mc_addr), '0);
            chk("rst_mc_we", e.cyc, DATA_W'(mc_we), '0);
            chk("rst_mc_wdata", e.cyc, mc_wdata, '0);
            chk("rst_rdata", e.cyc, rdata, '0);
          end
          if (e.has_cmd) begin
            chk("gnt", e.cyc, DATA_W'(gnt), DATA_W'(3'b001 << e.cmd_idx));
            chk("mc_addr", e.cyc, DATA_W'(mc_addr), DATA_W'(e.cmd_addr));
            chk("mc_we", e.cyc, DATA_W'(mc_we), DATA_W'(e.cmd_we));
            if (e.cmd_we) chk("mc_wdata", e.cyc, mc_wdata, e.cmd_wdata);
          end else begin
            chk("gnt_idle", e.cyc, DATA_W'(gnt), '0);
          end
          if (e.has_rsp && !e.rsp_err) begin
            chk("rvalid", e.cyc, DATA_W'(rvalid), DATA_W'(3'b001 << e.rsp_idx));
            chk("rdata", e.cyc, rdata, e.rsp_data);
          end else begin
            chk("rvalid_idle", e.cyc, DATA_W'(rvalid), '0);
          end
          chk("rd_err", e.cyc, DATA_W'(rd_err), DATA_W'(e.has_rsp && e.rsp_err));
        end
      end
    end
  end

  // Driver and reference model: sets this cycle's inputs, then predicts
  initial begin
    exp_t e;
    logic rst_prev;
    logic others;
    logic vid_gnt;
    logic any_gnt;
    logic gen_en;
    int   phy_lo;
    int   n_rst;
    int   w;

    rst = 1'b1; phy_init_done = 1'b0; req = 3'b000; we = 3'b000;
    addr = '0; wdata = '0; mc_rdy = 1'b0; mc_rvalid = 1'b0; mc_rdata = '0;
    pend = 3'b000; pop_pend = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cur_we[i] = 1'b0; cur_addr[i] = '0; cur_wdata[i] = '0;
    end
    phase = P_FREE; act_idx = 0; act_we = 1'b0; act_addr = '0; act_wdata = '0;
    wait_k = 0; withhold = 1'b0; streak = 0; rr_npu = 1'b0;
    rst_prev = 1'b0; phy_lo = 0; n_rst = 0;

    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk);
      #1;
      gen_en = (c >= 3) && (c < N_CYC - 100);

      for (int i = 0; i < 3; i++) begin
        if (pop_pend[i]) begin
          pend[i] = 1'b0;
          pop_pend[i] = 1'b0;
        end
      end
      if (c == 3) begin
        for (int i = 0; i < 3; i++) new_txn(i);
      end
      if (gen_en) begin
        for (int i = 0; i < 3; i++) begin
          if (!pend[i] && $urandom_range(0, 99) < ((i == 2) ? 70 : 55)) new_txn(i);
        end
      end

      // Reset for 3 cycles, PHY not ready for 20, then brief random drops
      rst = (c < 3);
      if (c >= 40 && gen_en && phase == P_WAIT && n_rst < 6 && $urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        n_rst++;
      end
      if (c < 23) begin
        phy_init_done = 1'b0;
      end else if (phy_lo > 0) begin
        phy_lo--;
        phy_init_done = 1'b0;
      end else begin
        phy_init_done = 1'b1;
        if (gen_en && $urandom_range(0, 99) < 2) phy_lo = $urandom_range(1, 6);
      end

      for (int i = 0; i < 3; i++) begin
        req[i] = pend[i];
        we[i]  = cur_we[i];
        addr[i*ADDR_W +: ADDR_W]  = cur_addr[i];
        wdata[i*DATA_W +: DATA_W] = cur_wdata[i];
      end

      mc_rdy   = ($urandom_range(0, 99) < 65);
      mc_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (phase == P_WAIT && !withhold) mc_rvalid = ($urandom_range(0, 99) < 35);
      else if (phase == P_WAIT) mc_rvalid = 1'b0;
      else mc_rvalid = ($urandom_range(0, 99) < 8);

      e.cyc = c; e.mc_req = (phase == P_ISSUE) && !rst; e.chk_zero = rst_prev;
      e.has_cmd = 1'b0; e.cmd_idx = 0; e.cmd_we = 1'b0; e.cmd_addr = '0; e.cmd_wdata = '0;
      e.has_rsp = 1'b0; e.rsp_err = 1'b0; e.rsp_idx = 0; e.rsp_data = '0;

      if (rst) begin
        phase = P_FREE; streak = 0; rr_npu = 1'b0;
      end else begin
        vid_gnt = 1'b0;
        any_gnt = 1'b0;
        others  = pend[0] | pend[1];
        if (phase == P_FREE) begin
          if (phy_init_done && pend != 3'b000) begin
            w = model_pick(pend, streak, rr_npu);
            act_idx = w; act_we = cur_we[w]; act_addr = cur_addr[w]; act_wdata = cur_wdata[w];
            phase = P_ISSUE;
          end
        end else if (phase == P_ISSUE) begin
          if (mc_rdy) begin
            e.has_cmd = 1'b1; e.cmd_idx = act_idx; e.cmd_we = act_we;
            e.cmd_addr = act_addr; e.cmd_wdata = act_wdata;
            any_gnt = 1'b1;
            vid_gnt = (act_idx == 2);
            if (act_idx != 2) rr_npu = (act_idx == 0);
            pop_pend[act_idx] = 1'b1;
            if (act_we) begin
              phase = P_FREE;
            end else begin
              phase = P_WAIT;
              wait_k = 0;
              withhold = ($urandom_range(0, 99) < 15);
            end
          end
        end else begin
          wait_k++;
          if (mc_rvalid) begin
            e.has_rsp = 1'b1; e.rsp_idx = act_idx; e.rsp_data = mc_rdata;
            phase = P_FREE;
          end else if (wait_k == RD_TMO) begin
            e.has_rsp = 1'b1; e.rsp_err = 1'b1;
            phase = P_FREE;
          end
        end
        if (vid_gnt && others) streak = (streak < VID_MAX) ? streak + 1 : VID_MAX;
        else if (any_gnt || !others) streak = 0;
      end
      rst_prev = rst;
      exp_q.push_back(e);
      mon_en = 1'b1;
    end

    @(negedge clk);
    #1;
    chk("sb_drained", N_CYC, DATA_W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
